// File: rtl/irrigation_pkg.sv
// Shared definitions for the tank level path: level encodings, FSM states,
// thermometer pattern constants and pattern decode helpers.
package irrigation_pkg;

   typedef enum logic [1:0] {
      LVL_EMPTY = 2'b00,
      LVL_LOW   = 2'b01,
      LVL_MID   = 2'b10,
      LVL_HIGH  = 2'b11
   } level_t;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_EMPTY,
      ST_LOW,
      ST_MID,
      ST_HIGH,
      ST_FAULT
   } state_t;

   // Sensor pattern is {high, mid, low}; only thermometer codes are physical.
   localparam logic [2:0] PAT_EMPTY = 3'b000;
   localparam logic [2:0] PAT_LOW   = 3'b001;
   localparam logic [2:0] PAT_MID   = 3'b011;
   localparam logic [2:0] PAT_HIGH  = 3'b111;

   // Per-sensor status handed from a debouncer to the level tracker.
   typedef struct packed {
      logic stable;   // accepted (debounced) value
      logic pending;  // synchronised value differs from the accepted one
      logic commit;   // accepted value updates on this clock edge
   } sensor_status_t;

   function automatic logic is_valid_pattern(input logic [2:0] p);
      return (p == PAT_EMPTY) || (p == PAT_LOW) || (p == PAT_MID) || (p == PAT_HIGH);
   endfunction

   // Invalid patterns decode to EMPTY; callers gate with is_valid_pattern().
   function automatic level_t pattern_to_level(input logic [2:0] p);
      level_t l;
      case (p)
         PAT_LOW:  l = LVL_LOW;
         PAT_MID:  l = LVL_MID;
         PAT_HIGH: l = LVL_HIGH;
         default:  l = LVL_EMPTY;
      endcase
      return l;
   endfunction

   function automatic state_t level_to_state(input level_t l);
      state_t s;
      case (l)
         LVL_LOW:  s = ST_LOW;
         LVL_MID:  s = ST_MID;
         LVL_HIGH: s = ST_HIGH;
         default:  s = ST_EMPTY;
      endcase
      return s;
   endfunction

   function automatic logic is_level_state(input state_t s);
      return (s == ST_EMPTY) || (s == ST_LOW) || (s == ST_MID) || (s == ST_HIGH);
   endfunction

   // Non-level states map to EMPTY; only meaningful for level states.
   function automatic level_t state_to_level(input state_t s);
      level_t l;
      case (s)
         ST_LOW:  l = LVL_LOW;
         ST_MID:  l = LVL_MID;
         ST_HIGH: l = LVL_HIGH;
         default: l = LVL_EMPTY;
      endcase
      return l;
   endfunction

   // Same level or one step apart; widened so HIGH and EMPTY never look adjacent.
   function automatic logic levels_adjacent(input level_t a, input level_t b);
      logic [2:0] wa;
      logic [2:0] wb;
      wa = {1'b0, a};
      wb = {1'b0, b};
      return (wa == wb) || (wa == wb + 3'd1) || (wb == wa + 3'd1);
   endfunction

endpackage

// File: rtl/sensor_debouncer.sv
// One tank sensor: two-flop synchroniser followed by a tick-based debouncer.
// A new synchronised value is accepted after DEBOUNCE_TICKS consecutive
// enabled ticks of disagreement with the accepted value.
module sensor_debouncer
   import irrigation_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 4,
   parameter int CNT_W          = 8
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           sample_enable,
   input  logic           raw_level,
   output sensor_status_t status
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

   logic             sync_q1;
   logic             sync_q2;
   logic             stable_q;
   logic [CNT_W-1:0] cnt_q;
   logic             differs;
   logic             commit;

   assign differs = (sync_q2 != stable_q);
   assign commit  = differs && sample_enable && (cnt_q >= CNT_LAST);

   // Synchroniser runs every clock, independent of the sample tick.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= raw_level;
         sync_q2 <= sync_q1;
      end
   end

   // Count enabled ticks of disagreement; any agreement restarts the count.
   always_ff @(posedge clock) begin
      if (reset) begin
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else if (!differs) begin
         cnt_q <= '0;
      end else if (sample_enable) begin
         if (cnt_q >= CNT_LAST) begin
            stable_q <= sync_q2;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign status.stable  = stable_q;
   assign status.pending = differs;
   assign status.commit  = commit;

endmodule

// File: rtl/water_level_sampler.sv
// Turns three raw tank sensors into a trusted level code. Each sensor is
// synchronised and debounced, the debounced pattern is tracked by a level FSM
// that rejects impossible patterns and impossible jumps via a FAULT state.
module water_level_sampler
   import irrigation_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 4,
   parameter int CONFLICT_TICKS = 3,
   parameter int CNT_W          = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       sample_enable,
   input  logic       low_water_level,
   input  logic       mid_water_level,
   input  logic       high_water_level,
   output logic [1:0] level_code,
   output logic       level_valid,
   output logic       conflicting_values,
   output logic       level_changed
);

   localparam int               NUM_SENSORS = 3;
   localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(DEBOUNCE_TICKS);
   localparam logic [CNT_W-1:0] CONF_LAST   = CNT_W'(CONFLICT_TICKS);

   logic           [NUM_SENSORS-1:0] raw;
   sensor_status_t [NUM_SENSORS-1:0] sts;
   logic           [NUM_SENSORS-1:0] pattern;
   logic                             any_commit;
   logic                             all_quiet;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] conf_cnt_q, conf_cnt_d;
   logic [CNT_W-1:0] init_cnt_q;
   logic             done_seen_q;
   level_t           level_code_q;
   logic             level_valid_q;
   logic             conflict_q;
   logic             changed_q;

   logic             p_valid;
   level_t           p_level;
   logic             init_ready;
   logic             tracking;

   assign raw = {high_water_level, mid_water_level, low_water_level};

   for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_sensor
      sensor_debouncer #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
         .CNT_W          (CNT_W)
      ) u_deb (
         .clock         (clock),
         .reset         (reset),
         .sample_enable (sample_enable),
         .raw_level     (raw[i]),
         .status        (sts[i])
      );
      assign pattern[i] = sts[i].stable;
   end

   // Collapse per-sensor status into "something settled" / "nothing pending".
   always_comb begin
      any_commit = 1'b0;
      all_quiet  = 1'b1;
      for (int i = 0; i < NUM_SENSORS; i++) begin
         any_commit = any_commit | sts[i].commit;
         all_quiet  = all_quiet & ~sts[i].pending;
      end
   end

   // INIT release: first accepted change, or a full debounce window of silence.
   always_ff @(posedge clock) begin
      if (reset) begin
         done_seen_q <= 1'b0;
         init_cnt_q  <= '0;
      end else begin
         if (any_commit) done_seen_q <= 1'b1;
         if (!all_quiet)
            init_cnt_q <= '0;
         else if (sample_enable && (init_cnt_q < INIT_LAST))
            init_cnt_q <= init_cnt_q + CNT_W'(1);
      end
   end

   assign p_valid    = is_valid_pattern(pattern);
   assign p_level    = pattern_to_level(pattern);
   assign init_ready = done_seen_q || (init_cnt_q >= INIT_LAST);

   // Next-state: level moves happen on any clock, conflict timing only on ticks.
   always_comb begin
      state_d    = state_q;
      conf_cnt_d = conf_cnt_q;
      tracking   = (state_q != ST_INIT) || init_ready;
      if (state_q == ST_FAULT) begin
         if (!p_valid) begin
            conf_cnt_d = '0;
         end else if (sample_enable) begin
            if (conf_cnt_q >= CONF_LAST) begin
               state_d    = level_to_state(p_level);
               conf_cnt_d = '0;
            end else begin
               conf_cnt_d = conf_cnt_q + CNT_W'(1);
            end
         end
      end else if (tracking) begin
         if (p_valid) begin
            conf_cnt_d = '0;
            if ((state_q == ST_INIT) || levels_adjacent(state_to_level(state_q), p_level))
               state_d = level_to_state(p_level);
            else
               state_d = ST_FAULT;
         end else if (sample_enable) begin
            if (conf_cnt_q >= CONF_LAST) begin
               state_d    = ST_FAULT;
               conf_cnt_d = '0;
            end else begin
               conf_cnt_d = conf_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // State and conflict counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_INIT;
         conf_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         conf_cnt_q <= conf_cnt_d;
      end
   end

   // Registered outputs derived from the next state so they move with it.
   always_ff @(posedge clock) begin
      if (reset) begin
         level_code_q  <= LVL_EMPTY;
         level_valid_q <= 1'b0;
         conflict_q    <= 1'b0;
         changed_q     <= 1'b0;
      end else begin
         level_valid_q <= is_level_state(state_d);
         conflict_q    <= (state_d == ST_FAULT);
         changed_q     <= (state_d != state_q);
         if (is_level_state(state_d)) level_code_q <= state_to_level(state_d);
      end
   end

   assign level_code         = level_code_q;
   assign level_valid        = level_valid_q;
   assign conflicting_values = conflict_q;
   assign level_changed      = changed_q;

endmodule

// File: tb/tb_water_level_sampler.sv
// Bench for water_level_sampler: directed scenarios plus randomised sensor
// activity, every clock compared with a behavioural model of the sampler.
module tb_water_level_sampler;

   localparam int DT = 4;
   localparam int CT = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       sample_enable = 1'b1;
   logic       low_water_level = 1'b0;
   logic       mid_water_level = 1'b0;
   logic       high_water_level = 1'b0;
   logic [1:0] level_code;
   logic       level_valid;
   logic       conflicting_values;
   logic       level_changed;

   int n_vec = 0;
   int n_err = 0;

   // Model: sensor index 0 = low, 1 = mid, 2 = high. Level -1 = INIT, 4 = FAULT.
   int s1 [3];
   int s2 [3];
   int st [3];
   int dc [3];
   bit m_done;
   int m_quiet;
   int m_lvl = -1;
   int m_cc;
   int m_code;
   bit m_valid;
   bit m_chg;

   always #5 clock = ~clock;

   water_level_sampler #(
      .DEBOUNCE_TICKS (DT),
      .CONFLICT_TICKS (CT),
      .CNT_W          (8)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .sample_enable      (sample_enable),
      .low_water_level    (low_water_level),
      .mid_water_level    (mid_water_level),
      .high_water_level   (high_water_level),
      .level_code         (level_code),
      .level_valid        (level_valid),
      .conflicting_values (conflicting_values),
      .level_changed      (level_changed)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_raw(input logic [2:0] p);
      {high_water_level, mid_water_level, low_water_level} = p;
   endtask

   // Model advance for one rising edge, using the inputs present at that edge.
   task automatic model_step();
      int  p, n, nl, ncc;
      bit  ok, quiet_now, commit_now;
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            s1[i] = 0; s2[i] = 0; st[i] = 0; dc[i] = 0;
         end
         m_done = 0; m_quiet = 0; m_lvl = -1; m_cc = 0;
         m_code = 0; m_valid = 0; m_chg = 0;
         return;
      end
      // Level tracking on the currently accepted pattern.
      p   = st[2] * 4 + st[1] * 2 + st[0];
      n   = $countones(p);
      ok  = (p == (1 << n) - 1);
      nl  = m_lvl;
      ncc = m_cc;
      if (m_lvl == 4) begin
         if (!ok) ncc = 0;
         else if (sample_enable) begin
            if (m_cc == CT) begin nl = n; ncc = 0; end
            else ncc = m_cc + 1;
         end
      end else if (m_lvl != -1 || m_done || m_quiet >= DT) begin
         if (ok) begin
            ncc = 0;
            if (m_lvl == -1 || (n - m_lvl <= 1 && m_lvl - n <= 1)) nl = n;
            else nl = 4;
         end else if (sample_enable) begin
            if (m_cc == CT) begin nl = 4; ncc = 0; end
            else ncc = m_cc + 1;
         end
      end
      m_chg   = (nl != m_lvl);
      m_valid = (nl >= 0 && nl <= 3);
      if (m_valid) m_code = nl;
      m_lvl = nl;
      m_cc  = ncc;
      // Debounce each sensor against its synchronised copy.
      quiet_now  = 1;
      commit_now = 0;
      for (int i = 0; i < 3; i++) begin
         if (s2[i] != st[i]) quiet_now = 0;
         if (s2[i] == st[i]) dc[i] = 0;
         else if (sample_enable) begin
            if (dc[i] == DT - 1) begin st[i] = s2[i]; dc[i] = 0; commit_now = 1; end
            else dc[i]++;
         end
      end
      if (commit_now) m_done = 1;
      if (!quiet_now) m_quiet = 0;
      else if (sample_enable && m_quiet < DT) m_quiet++;
      // Synchroniser.
      s2[0] = s1[0]; s2[1] = s1[1]; s2[2] = s1[2];
      s1[0] = int'(low_water_level);
      s1[1] = int'(mid_water_level);
      s1[2] = int'(high_water_level);
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      chk("model_code", {6'd0, level_code}, 8'(m_code));
      chk("model_valid", {7'd0, level_valid}, {7'd0, m_valid});
      chk("model_conflict", {7'd0, conflicting_values}, {7'd0, m_lvl == 4});
      chk("model_changed", {7'd0, level_changed}, {7'd0, m_chg});
   endtask

   logic [2:0] valid_pats [4] = '{3'b000, 3'b001, 3'b011, 3'b111};

   initial begin
      // Reset state.
      reset = 1'b1; sample_enable = 1'b1; set_raw(3'b000);
      tick(); tick();
      chk("rst_code", {6'd0, level_code}, 8'd0);
      chk("rst_valid", {7'd0, level_valid}, 8'd0);
      chk("rst_conflict", {7'd0, conflicting_values}, 8'd0);
      chk("rst_changed", {7'd0, level_changed}, 8'd0);

      // Apply 011 at reset release: MID exactly 7 clocks later, one pulse.
      reset = 1'b0; set_raw(3'b011);
      repeat (6) begin
         tick();
         chk("t1_wait_valid", {7'd0, level_valid}, 8'd0);
         chk("t1_wait_changed", {7'd0, level_changed}, 8'd0);
      end
      tick();
      chk("t1_code", {6'd0, level_code}, 8'd2);
      chk("t1_valid", {7'd0, level_valid}, 8'd1);
      chk("t1_changed", {7'd0, level_changed}, 8'd1);
      tick();
      chk("t1_pulse_end", {7'd0, level_changed}, 8'd0);
      repeat (3) tick();

      // Two-clock glitch on the high sensor is filtered.
      set_raw(3'b111); tick(); tick(); set_raw(3'b011);
      repeat (10) begin
         tick();
         chk("t2_code", {6'd0, level_code}, 8'd2);
         chk("t2_valid", {7'd0, level_valid}, 8'd1);
         chk("t2_changed", {7'd0, level_changed}, 8'd0);
      end

      // Invalid 101 held: FAULT after 7+3 clocks, then recover to MID.
      set_raw(3'b101);
      repeat (9) begin
         tick();
         chk("t3_pre_conflict", {7'd0, conflicting_values}, 8'd0);
      end
      tick();
      chk("t3_conflict", {7'd0, conflicting_values}, 8'd1);
      chk("t3_valid", {7'd0, level_valid}, 8'd0);
      chk("t3_code_held", {6'd0, level_code}, 8'd2);
      set_raw(3'b011);
      repeat (9) begin
         tick();
         chk("t3_still_fault", {7'd0, conflicting_values}, 8'd1);
      end
      tick();
      chk("t3_recover_conflict", {7'd0, conflicting_values}, 8'd0);
      chk("t3_recover_valid", {7'd0, level_valid}, 8'd1);
      chk("t3_recover_code", {6'd0, level_code}, 8'd2);
      repeat (3) tick();

      // MID -> LOW, then LOW -> 111 jumps straight to FAULT.
      set_raw(3'b001); repeat (8) tick();
      chk("t4_low_code", {6'd0, level_code}, 8'd1);
      set_raw(3'b111);
      repeat (6) begin
         tick();
         chk("t4_no_mid", {6'd0, level_code}, 8'd1);
      end
      tick();
      chk("t4_fault", {7'd0, conflicting_values}, 8'd1);
      chk("t4_fault_code", {6'd0, level_code}, 8'd1);
      repeat (6) tick();
      chk("t4_high_code", {6'd0, level_code}, 8'd3);
      set_raw(3'b011); repeat (8) tick();
      set_raw(3'b001); repeat (8) tick();
      chk("t5_start_code", {6'd0, level_code}, 8'd1);

      // Sample tick every other clock: 001 -> 011 takes 2+8+1 clocks.
      set_raw(3'b011);
      for (int k = 1; k <= 10; k++) begin
         sample_enable = (k % 2 == 0);
         tick();
         chk("t5_wait_code", {6'd0, level_code}, 8'd1);
      end
      sample_enable = 1'b0;
      tick();
      chk("t5_code", {6'd0, level_code}, 8'd2);
      chk("t5_changed", {7'd0, level_changed}, 8'd1);
      sample_enable = 1'b1;
      repeat (3) tick();

      // Reset two ticks into a debounce, then a full re-debounce.
      set_raw(3'b001);
      repeat (4) tick();
      reset = 1'b1;
      tick();
      chk("t6_code", {6'd0, level_code}, 8'd0);
      chk("t6_valid", {7'd0, level_valid}, 8'd0);
      chk("t6_conflict", {7'd0, conflicting_values}, 8'd0);
      reset = 1'b0;
      repeat (6) begin
         tick();
         chk("t6_redebounce", {7'd0, level_valid}, 8'd0);
      end
      tick();
      chk("t6_low_code", {6'd0, level_code}, 8'd1);
      chk("t6_low_changed", {7'd0, level_changed}, 8'd1);

      // Randomised sensor activity with sporadic ticks and resets.
      for (int seg = 0; seg < 300; seg++) begin
         int len;
         if ($urandom_range(0, 9) < 7) set_raw(valid_pats[$urandom_range(0, 3)]);
         else set_raw(3'($urandom_range(0, 7)));
         len = $urandom_range(1, 12);
         for (int j = 0; j < len; j++) begin
            sample_enable = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 199) == 0);
            tick();
         end
      end
      reset = 1'b0; sample_enable = 1'b1;
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
